// File: rtl/jstk_pkg.sv
// jstk_pkg: shared types and constants for the PmodJSTK SPI reader.
// Centre-deadzone helper is applied only when built with JSTK_DEADZONE_EN.
`default_nettype none

package jstk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } jstk_state_t;

    localparam logic [9:0] JSTK_CENTER     = 10'd512;
    localparam logic [5:0] JSTK_LED_PREFIX = 6'b100000;
    localparam int         JSTK_NUM_BYTES  = 5;

    // Snap an axis reading to centre when it lies within +/-dz of it.
    function automatic logic [9:0] jstk_deadzone(input logic [9:0] v, input int dz, input logic en);
        int diff;
        diff = int'({22'd0, v}) - int'({22'd0, JSTK_CENTER});
        if (en && (diff <= dz) && (diff >= -dz)) begin
            return JSTK_CENTER;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jstk_spi_reader_shifter.sv
// spi_byte_shifter: one SPI mode-0 byte transfer, MSB first, sclk idle low.
// done is asserted combinationally on the cycle the 8th falling edge is produced.
`default_nettype none

module spi_byte_shifter #(
    parameter int SCLK_DIV = 50
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx,
    output logic       done
);

    localparam int DW = $clog2(SCLK_DIV);

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    tx_rest;
    logic          tick;

    assign tick = active && (div_cnt == DW'(SCLK_DIV - 1));
    assign done = tick && sclk && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            tx_rest <= 7'd0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            rx      <= 8'd0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            tx_rest <= tx[6:0];
            sclk    <= 1'b0;
            mosi    <= tx[7];
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (!sclk) begin
                    rx <= {rx[6:0], miso};
                end else if (bit_cnt == 3'd7) begin
                    // Byte complete: park the bus low until the next start.
                    active <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    mosi    <= tx_rest[6];
                    tx_rest <= {tx_rest[5:0], 1'b0};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jstk_spi_reader.sv
// jstk_spi_reader: periodic PmodJSTK poller producing 10-bit X/Y and button states.
// Optional centre deadzone enabled by defining JSTK_DEADZONE_EN.
`default_nettype none

module jstk_spi_reader
    import jstk_pkg::*;
#(
    parameter int SCLK_DIV    = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1000000,
    parameter int DEADZONE    = 32
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       sample_valid,
    output logic       busy
);

    localparam int PH_MAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PC_W   = $clog2(POLL_PERIOD + 1);

`ifdef JSTK_DEADZONE_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    jstk_state_t     state;
    logic [PC_W-1:0] poll_cnt;
    logic            pending;
    logic [PH_W-1:0] phase_cnt;
    logic [2:0]      byte_idx;
    logic [7:0]      tx0;
    logic [7:0]      rx0;
    logic [1:0]      rx1;
    logic [7:0]      rx2;
    logic [1:0]      rx3;

    logic            poll_expire;
    logic            shift_start;
    logic            shift_done;
    logic [7:0]      shift_tx;
    logic [7:0]      shift_rx;
    logic [9:0]      raw_x;
    logic [9:0]      raw_y;

    assign poll_expire = (poll_cnt == PC_W'(POLL_PERIOD - 1));
    assign shift_start = ((state == SETUP) && (phase_cnt == PH_W'(SS_SETUP - 1))) ||
                         ((state == GAP)   && (phase_cnt == PH_W'(BYTE_GAP - 1)));
    assign shift_tx    = (byte_idx == 3'd0) ? tx0 : 8'h00;
    assign raw_x       = {rx1, rx0};
    assign raw_y       = {rx3, rx2};

    spi_byte_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .clr   (clr),
        .start (shift_start),
        .tx    (shift_tx),
        .miso  (miso),
        .sclk  (sclk),
        .mosi  (mosi),
        .rx    (shift_rx),
        .done  (shift_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            poll_cnt     <= '0;
            pending      <= 1'b0;
            phase_cnt    <= '0;
            byte_idx     <= 3'd0;
            tx0          <= 8'd0;
            rx0          <= 8'd0;
            rx1          <= 2'd0;
            rx2          <= 8'd0;
            rx3          <= 2'd0;
            ss_n         <= 1'b1;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            joy_x        <= JSTK_CENTER;
            joy_y        <= JSTK_CENTER;
            btn          <= 3'd0;
        end else begin
            sample_valid <= 1'b0;
            poll_cnt     <= poll_expire ? '0 : poll_cnt + 1'b1;

            // Poll period is start-to-start: an expiry mid-transaction is deferred.
            if (poll_expire && (state != IDLE) && (state != DONE)) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (poll_expire || pending) begin
                        pending   <= 1'b0;
                        tx0       <= {JSTK_LED_PREFIX, led};
                        ss_n      <= 1'b0;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                        byte_idx  <= 3'd0;
                        state     <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP, GAP: begin
                    if (shift_start) begin
                        state <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        if (byte_idx < 3'(JSTK_NUM_BYTES - 1)) begin
                            case (byte_idx)
                                3'd0:    rx0 <= shift_rx;
                                3'd1:    rx1 <= shift_rx[1:0];
                                3'd2:    rx2 <= shift_rx;
                                default: rx3 <= shift_rx[1:0];
                            endcase
                            byte_idx  <= byte_idx + 3'd1;
                            phase_cnt <= '0;
                            state     <= GAP;
                        end else begin
                            joy_x        <= jstk_deadzone(raw_x, DEADZONE, DZ_EN);
                            joy_y        <= jstk_deadzone(raw_y, DEADZONE, DZ_EN);
                            btn          <= shift_rx[2:0];
                            ss_n         <= 1'b1;
                            busy         <= 1'b0;
                            sample_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jstk_spi_reader.sv
// Self-checking bench for jstk_spi_reader with a behavioural PmodJSTK slave.
// Deadzone expectations follow JSTK_DEADZONE_EN when the bench is built with it.
`default_nettype none
`timescale 1ns/1ps

module tb_jstk_spi_reader;

    localparam int SCLK_DIV    = 2;
    localparam int SS_SETUP    = 4;
    localparam int BYTE_GAP    = 3;
    localparam int POLL_PERIOD = 400;
    localparam int DEADZONE    = 32;
    // ss_n low window: setup, five bytes of 16 half-periods, four inter-byte gaps
    localparam int TXN_LEN     = SS_SETUP + 5 * 16 * SCLK_DIV + 4 * BYTE_GAP;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [1:0] led = 2'b11;
    logic       miso = 1'b0;
    logic       ss_n, sclk, mosi, sample_valid, busy;
    logic [9:0] joy_x, joy_y;
    logic [2:0] btn;

    int          k;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_sv = 0;
    int          n_done = 0;
    logic [39:0] txn_vec;

    always #5 clk = ~clk;

    jstk_spi_reader #(
        .SCLK_DIV    (SCLK_DIV),
        .SS_SETUP    (SS_SETUP),
        .BYTE_GAP    (BYTE_GAP),
        .POLL_PERIOD (POLL_PERIOD),
        .DEADZONE    (DEADZONE)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .led          (led),
        .miso         (miso),
        .ss_n         (ss_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .joy_x        (joy_x),
        .joy_y        (joy_y),
        .btn          (btn),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    // Clock edges since the last release of clr.
    always @(posedge clk or posedge clr) begin
        if (clr) k <= 0;
        else     k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (k=%0d)", name, act, exp, k);
    endtask

    function automatic int dz_model(input int v);
`ifdef JSTK_DEADZONE_EN
        if ((v - 512 <= DEADZONE) && (512 - v <= DEADZONE)) return 512;
`endif
        return v;
    endfunction

    task automatic wait_k(input int target);
        for (int i = 0; i < 5000 && k != target; i++) @(negedge clk);
        if (k != target) check("wait_timeout", k, target);
        #1;
    endtask

    // Reference model, SPI slave and per-cycle comparison.
    initial begin : monitor
        logic [39:0] m_vec, s_vec, s_mosi;
        logic [1:0]  s_led;
        logic        e_ss, e_sv, prev_ss, prev_sclk;
        bit          s_act, s_gap_ok;
        int          ex, ey, eb, t, n, s_r, s_f, s_fall_k, s_first, s_last;
        ex = 512; ey = 512; eb = 0; e_ss = 1'b1; e_sv = 1'b0;
        prev_ss = 1'b1; prev_sclk = 1'b0; s_act = 0; s_gap_ok = 1;
        m_vec = '0; s_vec = '0; s_mosi = '0; s_led = 2'b00;
        s_r = 0; s_f = 0; s_fall_k = 0; s_first = 0; s_last = 0;
        forever begin
            @(negedge clk);
            if (clr) begin
                ex = 512; ey = 512; eb = 0; e_ss = 1'b1; e_sv = 1'b0;
                s_act = 0; miso = 1'b0;
            end else begin
                t = k % POLL_PERIOD;
                n = k / POLL_PERIOD;
                if (n >= 1 && t == 0) m_vec = txn_vec;
                e_ss = !(n >= 1 && t < TXN_LEN);
                e_sv = (n >= 1 && t == TXN_LEN);
                if (e_sv) begin
                    ex = dz_model(int'(m_vec[25:24]) * 256 + int'(m_vec[39:32]));
                    ey = dz_model(int'(m_vec[9:8]) * 256 + int'(m_vec[23:16]));
                    eb = int'(m_vec[2:0]);
                end
                if (prev_ss && !ss_n) begin
                    s_vec = txn_vec; s_led = led; s_act = 1; s_r = 0; s_f = 0;
                    s_mosi = '0; s_fall_k = k; s_first = -1; s_gap_ok = 1;
                    miso = s_vec[39];
                end else if (s_act) begin
                    if (!prev_sclk && sclk) begin
                        s_r++;
                        s_mosi = {s_mosi[38:0], mosi};
                        if (s_r == 1) s_first = k - s_fall_k;
                        else if (((s_r - 1) % 8 == 0) && (k - s_last != 5)) s_gap_ok = 0;
                    end
                    if (prev_sclk && !sclk) begin
                        s_f++;
                        s_last = k;
                        miso = (s_f < 40) ? s_vec[39 - s_f] : 1'b0;
                    end
                    if (!prev_ss && ss_n) begin
                        s_act = 0;
                        n_done++;
                        check("sclk_rises", s_r, 40);
                        check("mosi_byte0", s_mosi[39:32], {6'b100000, s_led});
                        check("mosi_bytes1to4", s_mosi[31:0], 32'h0);
                        check("ss_fall_to_first_rise", s_first, 6);
                        check("last_fall_to_next_rise", 32'(s_gap_ok), 1);
                        miso = 1'b0;
                    end
                end
            end
            if (sample_valid === 1'b1) n_sv++;
            check("cycle", {5'd0, ss_n, busy, sample_valid, (e_ss ? sclk : 1'b0), joy_x, joy_y, btn},
                  {5'd0, e_ss, ~e_ss, e_sv, 1'b0, 10'(ex), 10'(ey), 3'(eb)});
            prev_ss = ss_n;
            prev_sclk = sclk;
        end
    end

    initial begin : stimulus
        txn_vec = {8'h34, 8'h02, 8'hC8, 8'h01, 8'h05};
        @(negedge clk); #1;
        check("rst_joy_x", joy_x, 512);
        check("rst_joy_y", joy_y, 512);
        check("rst_btn", btn, 0);
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_sample_valid", sample_valid, 0);
        @(posedge clk); @(posedge clk); #1 clr = 1'b0;

        wait_k(399);
        check("ss_n_before_400", ss_n, 1);
        wait_k(400);
        check("ss_n_at_400", ss_n, 0);
        wait_k(577);
        check("t1_joy_x", joy_x, 564);
        check("t1_joy_y", joy_y, 456);
        check("t1_btn", btn, 3'b101);
        check("t1_sv_count", n_sv, 1);

        txn_vec = {8'h00, 8'hFE, 8'h00, 8'hFD, 8'hF8};
        led = 2'b01;
        wait_k(977);
        check("t2_joy_x", joy_x, 512);
        check("t2_joy_y", joy_y, 256);
        check("t2_btn", btn, 0);

        txn_vec = {8'h12, 8'h02, 8'hE0, 8'h01, 8'h00};
        led = 2'b10;
        wait_k(1377);
`ifdef JSTK_DEADZONE_EN
        check("t3_joy_x", joy_x, 512);
        check("t3_joy_y", joy_y, 512);
`else
        check("t3_joy_x", joy_x, 530);
        check("t3_joy_y", joy_y, 480);
`endif

        txn_vec = {8'h21, 8'h02, 8'h58, 8'h02, 8'h02};
        wait_k(1777);
        check("t4_joy_x", joy_x, 545);
        check("t4_joy_y", joy_y, 600);
        check("t4_btn", btn, 3'b010);

        txn_vec = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wait_k(2090);
        check("t5_busy_mid_byte2", busy, 1);
        @(posedge clk); #1 clr = 1'b1;
        #1;
        check("abort_ss_n", ss_n, 1);
        check("abort_joy_x", joy_x, 512);
        check("abort_sample_valid", sample_valid, 0);
        txn_vec = {8'hFF, 8'h03, 8'h00, 8'h00, 8'h07};
        led = 2'b11;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        check("abort_sv_count", n_sv, 4);

        wait_k(577);
        check("t6_joy_x", joy_x, 1023);
        check("t6_joy_y", joy_y, 0);
        check("t6_btn", btn, 3'b111);
        check("total_sv_count", n_sv, 5);
        check("completed_txns", n_done, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
